// File: rtl/rx_alu_interface_pkg.sv
// Shared widths, opcode constants, FSM encoding and opcode validity check
// for the UART-fed ALU interface.
package rx_alu_interface_pkg;

  localparam int N_DATA = 8;
  localparam int N_OP   = 6;

  typedef enum logic [2:0] {
    ST_GET_A,
    ST_GET_B,
    ST_GET_OP,
    ST_COMPUTE,
    ST_WAIT_TX
  } state_t;

  localparam logic [N_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [N_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [N_OP-1:0] OP_AND = 6'b100100;
  localparam logic [N_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [N_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [N_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [N_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [N_OP-1:0] OP_SRL = 6'b000010;

  // A received opcode byte is valid only if its bits above the opcode field are zero.
  function automatic logic op_valid(input logic [N_DATA-1:0] op);
    logic ok;
    ok = 1'b0;
    if (op[N_DATA-1:N_OP] == '0) begin
      case (op[N_OP-1:0])
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_NOR, OP_SRA, OP_SRL: ok = 1'b1;
        default:                        ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/rx_alu_interface_alu.sv
// Purely combinational ALU; any invalid opcode byte yields a zero result.
module alu #(
  parameter int N_DATA = rx_alu_interface_pkg::N_DATA,
  parameter int N_OP   = rx_alu_interface_pkg::N_OP
) (
  input  logic [N_DATA-1:0] A,
  input  logic [N_DATA-1:0] B,
  input  logic [N_DATA-1:0] OP,
  output logic [N_DATA-1:0] result
);
  import rx_alu_interface_pkg::*;

  logic signed [N_DATA-1:0] a_s;
  logic        [2:0]        shamt;

  assign a_s   = $signed(A);
  assign shamt = B[2:0];

  always_comb begin
    result = '0;
    if (op_valid(OP)) begin
      case (OP[N_OP-1:0])
        OP_ADD:  result = A + B;
        OP_SUB:  result = A - B;
        OP_AND:  result = A & B;
        OP_OR:   result = A | B;
        OP_XOR:  result = A ^ B;
        OP_NOR:  result = ~(A | B);
        OP_SRA:  result = a_s >>> shamt;
        OP_SRL:  result = A >> shamt;
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/rx_alu_interface.sv
// Collects an A, B, opcode byte triple from UART RX, computes one ALU result
// and requests a single TX of it, then waits for the transmitter to finish.
module rx_alu_interface #(
  parameter int N_DATA = rx_alu_interface_pkg::N_DATA,
  parameter int N_OP   = rx_alu_interface_pkg::N_OP
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_rx_done,
  input  logic [N_DATA-1:0] i_rx_data,
  input  logic              i_tx_done,
  output logic              o_tx_start,
  output logic [N_DATA-1:0] o_tx_data,
  output logic              o_busy,
  output logic              o_op_error
);
  import rx_alu_interface_pkg::*;

  state_t            state_q, state_d;
  logic [N_DATA-1:0] a_q, b_q, op_q;
  logic [N_DATA-1:0] alu_result;

  alu #(.N_DATA(N_DATA), .N_OP(N_OP)) u_alu (
    .A      (a_q),
    .B      (b_q),
    .OP     (op_q),
    .result (alu_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_GET_A:   if (i_rx_done) state_d = ST_GET_B;
      ST_GET_B:   if (i_rx_done) state_d = ST_GET_OP;
      ST_GET_OP:  if (i_rx_done) state_d = ST_COMPUTE;
      ST_COMPUTE: state_d = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done) state_d = ST_GET_A;
      default:    state_d = ST_GET_A;
    endcase
  end

  // Operand capture and result registers; RX bytes outside the GET_* states fall through.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_GET_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_op_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      o_tx_start <= 1'b0;
      case (state_q)
        ST_GET_A:  if (i_rx_done) a_q  <= i_rx_data;
        ST_GET_B:  if (i_rx_done) b_q  <= i_rx_data;
        ST_GET_OP: if (i_rx_done) op_q <= i_rx_data;
        ST_COMPUTE: begin
          o_tx_data  <= alu_result;
          o_tx_start <= 1'b1;
          o_op_error <= !op_valid(op_q);
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state_q == ST_COMPUTE) || (state_q == ST_WAIT_TX);

endmodule

// File: tb/tb_rx_alu_interface.sv
// Scoreboard bench: stimulus pushes the hand-computed result for each triple,
// a monitor pops and compares on every o_tx_start pulse.
module tb_rx_alu_interface;

  logic       i_clock   = 1'b0;
  logic       i_reset   = 1'b0;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_tx_done = 1'b0;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_busy;
  logic       o_op_error;

  rx_alu_interface dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_rx_done  (i_rx_done),
    .i_rx_data  (i_rx_data),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_busy     (o_busy),
    .o_op_error (o_op_error)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         when;
  } exp_t;

  exp_t q[$];
  int   errors     = 0;
  int   checks     = 0;
  int   starts     = 0;
  int   exp_starts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge i_clock) begin
    if (i_reset && o_tx_start) begin
      exp_t e;
      starts++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got tx_start with data %0h, required no start", o_tx_data);
      end else begin
        e = q.pop_front();
        check("tx_data", {24'h0, o_tx_data}, {24'h0, e.data});
        check("op_error", {31'h0, o_op_error}, {31'h0, e.err});
        check("start_latency", cyc, e.when);
        check("busy_at_start", {31'h0, o_busy}, 32'h1);
      end
    end
  end

  task automatic rx(input logic [7:0] b);
    @(negedge i_clock);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clock);
    i_rx_done = 1'b0;
  endtask

  task automatic tx_done_pulse();
    @(negedge i_clock);
    i_tx_done = 1'b1;
    @(negedge i_clock);
    i_tx_done = 1'b0;
  endtask

  // The opcode byte is driven at the negedge where cyc reads c; the start must appear at c+2.
  task automatic triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input logic [7:0] res, input logic err);
    exp_t e;
    rx(a);
    rx(b);
    @(negedge i_clock);
    e.data = res;
    e.err  = err;
    e.when = cyc + 2;
    q.push_back(e);
    exp_starts++;
    i_rx_data = op;
    i_rx_done = 1'b1;
    @(negedge i_clock);
    i_rx_done = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge i_clock);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge i_clock);
  endtask

  task automatic finish_tx();
    drain();
    tx_done_pulse();
    check("busy_after_tx_done", {31'h0, o_busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge i_clock);
    check("reset_tx_start", {31'h0, o_tx_start}, 32'h0);
    check("reset_tx_data", {24'h0, o_tx_data}, 32'h0);
    check("reset_busy", {31'h0, o_busy}, 32'h0);
    check("reset_op_error", {31'h0, o_op_error}, 32'h0);
    i_reset = 1'b1;

    // Stray tx_done in GET_A must not matter.
    tx_done_pulse();

    triple(8'h05, 8'h03, 8'h20, 8'h08, 1'b0);
    check("busy_in_wait", {31'h0, o_busy}, 32'h1);
    finish_tx();
    triple(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0);
    finish_tx();
    triple(8'h80, 8'h01, 8'h03, 8'hC0, 1'b0);
    finish_tx();
    triple(8'h80, 8'h01, 8'h02, 8'h40, 1'b0);
    finish_tx();
    triple(8'h80, 8'h0F, 8'h03, 8'hFF, 1'b0);
    finish_tx();
    triple(8'h12, 8'h34, 8'h3F, 8'h00, 1'b1);
    finish_tx();
    triple(8'h0F, 8'h30, 8'h27, 8'hC0, 1'b0);
    finish_tx();
    triple(8'h11, 8'h22, 8'h60, 8'h00, 1'b1);
    finish_tx();
    triple(8'hFF, 8'h0F, 8'h26, 8'hF0, 1'b0);
    finish_tx();

    // tx_done between operands must be ignored: A=F0, B=3C, AND -> 30.
    begin
      exp_t e;
      rx(8'hF0);
      tx_done_pulse();
      rx(8'h3C);
      tx_done_pulse();
      @(negedge i_clock);
      e.data = 8'h30; e.err = 1'b0; e.when = cyc + 2;
      q.push_back(e);
      exp_starts++;
      i_rx_data = 8'h24;
      i_rx_done = 1'b1;
      @(negedge i_clock);
      i_rx_done = 1'b0;
    end
    drain();
    rx(8'hAA);
    tx_done_pulse();
    triple(8'h01, 8'h01, 8'h20, 8'h02, 1'b0);
    finish_tx();

    // Reset after operand A only.
    rx(8'h77);
    i_reset = 1'b0;
    #2;
    check("midreset_busy", {31'h0, o_busy}, 32'h0);
    check("midreset_tx_data", {24'h0, o_tx_data}, 32'h0);
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    triple(8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0);
    finish_tx();

    // Reset while in COMPUTE: the triple is discarded and no start may follow.
    rx(8'h11);
    rx(8'h22);
    rx(8'h20);
    i_reset = 1'b0;
    #2;
    check("compute_reset_busy", {31'h0, o_busy}, 32'h0);
    check("compute_reset_start", {31'h0, o_tx_start}, 32'h0);
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    repeat (6) @(negedge i_clock);
    check("no_start_after_reset", starts, exp_starts);
    triple(8'h01, 8'h02, 8'h20, 8'h03, 1'b0);
    finish_tx();

    repeat (5) @(negedge i_clock);
    check("start_count", starts, exp_starts);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
